fuzz_out_signature: RTL and testbench

- Downstream consumer of the fuzz DUT's flattened output bus.
- Samples the output bus once per enabled cycle and compresses it into a 32-bit MISR signature per fixed-length window.
- Also counts output changes per window and presents each window's result through a valid/ready snapshot port.
- Cross-simulator comparison then reduces to comparing short snapshot streams instead of full per-cycle output dumps.

---
 rtl/fuzz_out_signature.sv | 132 +++++++++++++
 tb/tb_fuzz_out_signature.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fuzz_out_signature.sv
// rtl/fuzz_out_signature.sv - windowed MISR signature and change counter over a fuzz DUT output bus
module fuzz_out_signature #(
    parameter int          OUT_W  = 330,
    parameter int          WINDOW = 16,
    parameter logic [31:0] POLY   = 32'h0040_0007,
    parameter logic [31:0] SEED   = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic [OUT_W-1:0] out_flat,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic [31:0]      snap_sig,
    output logic [15:0]      snap_changes,
    output logic [15:0]      snap_index,
    output logic             overrun,
    output logic             busy
);

    localparam int          NCH   = (OUT_W + 31) / 32;
    localparam int          PADW  = NCH * 32;
    localparam logic [15:0] WIN_L = 16'(WINDOW);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ACC  = 1'b1;

    logic [0:0]       state_q;
    logic [31:0]      sig_q;
    logic [15:0]      cnt_q;
    logic [15:0]      chg_q;
    logic [15:0]      idx_q;
    logic [OUT_W-1:0] prev_q;

    logic             snap_valid_q;
    logic [31:0]      snap_sig_q;
    logic [15:0]      snap_chg_q;
    logic [15:0]      snap_idx_q;
    logic             overrun_q;

    logic [PADW-1:0]  padded;
    logic [31:0]      fold;
    logic [31:0]      sig_d;
    logic [15:0]      cnt_d;
    logic [15:0]      chg_d;
    logic             changed;
    logic             close;

    // Fold the zero-extended bus to 32 bits and compute the next MISR/count values
    always_comb begin
        padded = '0;
        padded[OUT_W-1:0] = out_flat;
        fold = '0;
        for (int c = 0; c < NCH; c++) begin
            fold = fold ^ padded[c*32 +: 32];
        end
        sig_d   = ({sig_q[30:0], 1'b0} ^ (sig_q[31] ? POLY : 32'h0)) ^ fold;
        changed = (out_flat != prev_q);
        chg_d   = (changed && chg_q != 16'hFFFF) ? chg_q + 16'd1 : chg_q;
        cnt_d   = cnt_q + 16'd1;
        close   = en && (cnt_d == WIN_L);
    end

    // Window accumulation: sample count, change count, signature and window index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            chg_q   <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
        end else if (clear) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            chg_q   <= '0;
            idx_q   <= '0;
            prev_q  <= '0;
        end else if (en) begin
            prev_q  <= out_flat;
            state_q <= ACC;
            if (close) begin
                sig_q <= SEED;
                cnt_q <= '0;
                chg_q <= '0;
                idx_q <= idx_q + 16'd1;
            end else begin
                sig_q <= sig_d;
                cnt_q <= cnt_d;
                chg_q <= chg_d;
            end
        end
    end

    // Snapshot handoff: load on close when the slot is free or being consumed, else drop and flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_valid_q <= 1'b0;
            snap_sig_q   <= '0;
            snap_chg_q   <= '0;
            snap_idx_q   <= '0;
            overrun_q    <= 1'b0;
        end else if (clear) begin
            snap_valid_q <= 1'b0;
            snap_sig_q   <= '0;
            snap_chg_q   <= '0;
            snap_idx_q   <= '0;
            overrun_q    <= 1'b0;
        end else if (close) begin
            if (!snap_valid_q || snap_ready) begin
                snap_valid_q <= 1'b1;
                snap_sig_q   <= sig_d;
                snap_chg_q   <= chg_d;
                snap_idx_q   <= idx_q;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (snap_valid_q && snap_ready) begin
            snap_valid_q <= 1'b0;
        end
    end

    assign snap_valid   = snap_valid_q;
    assign snap_sig     = snap_sig_q;
    assign snap_changes = snap_chg_q;
    assign snap_index   = snap_idx_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q == ACC) && (cnt_q != 16'd0);

endmodule

// File: tb/tb_fuzz_out_signature.sv
// tb/tb_fuzz_out_signature.sv - directed scoreboard bench for fuzz_out_signature
module tb_fuzz_out_signature;

    localparam int          OUT_W = 330;
    localparam int          W     = 4;
    localparam logic [31:0] POLY  = 32'h0040_0007;
    localparam logic [31:0] SEED  = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             clear = 1'b0;
    logic [OUT_W-1:0] out_flat = '0;
    logic             snap_valid;
    logic             snap_ready = 1'b0;
    logic [31:0]      snap_sig;
    logic [15:0]      snap_changes;
    logic [15:0]      snap_index;
    logic             overrun;
    logic             busy;

    fuzz_out_signature #(.OUT_W(OUT_W), .WINDOW(W), .POLY(POLY), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .en(en), .clear(clear), .out_flat(out_flat),
        .snap_valid(snap_valid), .snap_ready(snap_ready), .snap_sig(snap_sig),
        .snap_changes(snap_changes), .snap_index(snap_index),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sig;
        logic [15:0] chg;
        logic [15:0] idx;
    } snap_t;

    snap_t            q[$];
    int               n_cmp = 0;
    int               n_bad = 0;

    logic [31:0]      m_sig;
    logic [15:0]      m_cnt;
    logic [15:0]      m_chg;
    logic [15:0]      m_idx;
    logic [OUT_W-1:0] m_prev;
    logic             m_valid;
    logic             m_overrun;

    function automatic logic [31:0] mfold(input logic [OUT_W-1:0] d);
        logic [31:0] f = '0;
        for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ d[i];
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sig = SEED; m_cnt = '0; m_chg = '0; m_idx = '0; m_prev = '0;
        m_valid = 1'b0; m_overrun = 1'b0;
        q.delete();
    endtask

    task automatic check_ctrl(input string tag);
        chk({tag, ".valid"}, 32'(snap_valid), 32'(m_valid));
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_overrun));
        chk({tag, ".busy"}, 32'(busy), 32'(m_cnt != 16'd0));
    endtask

    // One clock edge: drive inputs, advance the reference model, sample #1 after the edge
    task automatic step(input logic e, input logic [OUT_W-1:0] d, input logic r);
        logic [31:0] ns;
        logic [15:0] nc;
        logic        cls = 1'b0;
        snap_t       s;
        en = e; out_flat = d; snap_ready = r;
        if (e) begin
            ns = ({m_sig[30:0], 1'b0} ^ (m_sig[31] ? POLY : 32'h0)) ^ mfold(d);
            nc = (d !== m_prev && m_chg != 16'hFFFF) ? m_chg + 16'd1 : m_chg;
            m_prev = d;
            if (m_cnt + 16'd1 == 16'(W)) begin
                cls = 1'b1;
                s.sig = ns; s.chg = nc; s.idx = m_idx;
                m_idx = m_idx + 16'd1;
                m_sig = SEED; m_cnt = '0; m_chg = '0;
            end else begin
                m_sig = ns; m_cnt = m_cnt + 16'd1; m_chg = nc;
            end
        end
        if (cls) begin
            if (!m_valid || r) begin
                if (m_valid) void'(q.pop_front());
                q.push_back(s);
                m_valid = 1'b1;
            end else begin
                m_overrun = 1'b1;
            end
        end else if (m_valid && r) begin
            void'(q.pop_front());
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_ctrl("step");
    endtask

    task automatic check_model(input string tag);
        n_cmp++;
        assert (q.size() > 0) else begin
            n_bad++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end
        if (q.size() > 0) begin
            chk({tag, ".sig"}, snap_sig, q[0].sig);
            chk({tag, ".chg"}, 32'(snap_changes), 32'(q[0].chg));
            chk({tag, ".idx"}, 32'(snap_index), 32'(q[0].idx));
        end
    endtask

    task automatic check_const(input string tag, input logic [31:0] s, input logic [15:0] c, input logic [15:0] i);
        chk({tag, ".sig_c"}, snap_sig, s);
        chk({tag, ".chg_c"}, 32'(snap_changes), 32'(c));
        chk({tag, ".idx_c"}, 32'(snap_index), 32'(i));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid0"}, 32'(snap_valid), 32'h0);
        chk({tag, ".sig0"}, snap_sig, 32'h0);
        chk({tag, ".chg0"}, 32'(snap_changes), 32'h0);
        chk({tag, ".idx0"}, 32'(snap_index), 32'h0);
        chk({tag, ".ovr0"}, 32'(overrun), 32'h0);
        chk({tag, ".busy0"}, 32'(busy), 32'h0);
    endtask

    task automatic zero_window(input string tag);
        for (int k = 0; k < W; k++) step(1'b1, '0, 1'b0);
        check_model(tag);
        check_const(tag, 32'h0, 16'd0, 16'd0);
        step(1'b0, '0, 1'b1);
    endtask

    logic [OUT_W-1:0] d;
    logic [OUT_W-1:0] pa;
    logic [OUT_W-1:0] pb;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Zero bus, latency: not valid after 3 samples, valid after the 4th
        for (int k = 0; k < W - 1; k++) step(1'b1, '0, 1'b0);
        chk("lat.pre", 32'(snap_valid), 32'h0);
        step(1'b1, '0, 1'b0);
        check_model("zero");
        check_const("zero", 32'h0, 16'd0, 16'd0);
        step(1'b0, '0, 1'b1);

        // LSB then zeros
        d = '0; d[0] = 1'b1;
        step(1'b1, d, 1'b0);
        for (int k = 0; k < W - 1; k++) step(1'b1, '0, 1'b0);
        check_model("lsb");
        check_const("lsb", 32'h0000_0008, 16'd2, 16'd1);
        step(1'b0, '0, 1'b1);

        // Bit 320 folds into chunk bit 0
        d = '0; d[320] = 1'b1;
        step(1'b1, d, 1'b0);
        for (int k = 0; k < W - 1; k++) step(1'b1, '0, 1'b0);
        check_model("b320");
        check_const("b320", 32'h0000_0008, 16'd2, 16'd2);
        step(1'b0, '0, 1'b1);

        // Bit 31 then zero exercises the feedback polynomial
        d = '0; d[31] = 1'b1;
        step(1'b1, '0, 1'b0);
        step(1'b1, '0, 1'b0);
        step(1'b1, d, 1'b0);
        step(1'b1, '0, 1'b0);
        check_model("poly");
        check_const("poly", POLY, 16'd2, 16'd3);
        step(1'b0, '0, 1'b1);

        // Contiguous then en-toggled window with the same data
        pa = '0; pa[7:0] = 8'hA5; pa[300] = 1'b1;
        pb = '0; pb[63:32] = 32'hDEAD_BEEF;
        step(1'b1, '0, 1'b0); step(1'b1, pa, 1'b0); step(1'b1, pb, 1'b0); step(1'b1, '0, 1'b0);
        check_model("contig");
        step(1'b0, '0, 1'b1);
        step(1'b1, '0, 1'b0); step(1'b0, pb, 1'b0);
        step(1'b1, pa, 1'b0); step(1'b0, '1, 1'b0);
        chk("gap.busy", 32'(busy), 32'h1);
        step(1'b1, pb, 1'b0); step(1'b0, pa, 1'b0);
        step(1'b1, '0, 1'b0);
        check_model("toggle");
        step(1'b0, '0, 1'b1);

        // Overrun: ready low across two closes, then raise ready
        rst = 1'b1; #1; rst = 1'b0; model_reset();
        for (int k = 0; k < W; k++) step(1'b1, '0, 1'b0);
        check_model("ovr.w0");
        for (int k = 0; k < W; k++) step(1'b1, '0, 1'b0);
        chk("ovr.flag", 32'(overrun), 32'h1);
        check_const("ovr.hold", 32'h0, 16'd0, 16'd0);
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < W; k++) step(1'b1, '0, 1'b0);
        check_model("ovr.w2");
        check_const("ovr.w2", 32'h0, 16'd0, 16'd2);
        chk("ovr.sticky", 32'(overrun), 32'h1);
        step(1'b0, '0, 1'b1);

        // Async reset mid-window with a pending snapshot
        for (int k = 0; k < W + 2; k++) step(1'b1, pa, 1'b0);
        chk("rst.pre", 32'(snap_valid), 32'h1);
        #3 rst = 1'b1;
        #1 check_all_zero("rst.async");
        model_reset();
        #1 rst = 1'b0;
        zero_window("rst.rerun");

        // Synchronous clear mid-window with a pending snapshot
        for (int k = 0; k < W + 2; k++) step(1'b1, pb, 1'b0);
        clear = 1'b1;
        #3 chk("clr.pre", 32'(snap_valid), 32'h1);
        @(posedge clk); #1;
        check_all_zero("clr.edge");
        clear = 1'b0;
        model_reset();
        zero_window("clr.rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
